lectura_rafaga: RTL and testbench
=================================

// Module: lectura_rafaga
// PURPOSE
//  Parametrised burst-read sequencer; next generation of the single-address read FSM.
//  On a start request it issues a run of register reads from dir_base upward over the
//  activa/fin bus handshake, returning each byte with its index and pulsing final at the end.
//  Sits between the control FSM and the register-bus interface; supports one-shot or continuous mode.
// PARAMETERS
//  ADDR_W    8   width of dir_base / dir_out
//  DATA_W    8   width of dato_in / dato_out
//  MAX_REGS  8   maximum reads per burst; larger num_regs values are clamped to this
//  CNT_W     4   width of num_regs / indice; must satisfy 2**CNT_W > MAX_REGS
//  TO_CYC    255 watchdog limit in cycles; only used with LECTURA_TIMEOUT_EN
// PORTS
//  clk        in  1       system clock, rising edge
//  reset      in  1       asynchronous, active-low reset
//  iniciar    in  1       start on rising edge; deasserting it mid-burst aborts the burst
//  dir_base   in  ADDR_W  first register address; latched at start
//  num_regs   in  CNT_W   number of reads; latched at start
//  modo       in  1       0 = one-shot, 1 = continuous (repeat burst while iniciar=1); latched at start
//  fin        in  1       bus transaction done; dato_in valid in the same cycle
//  dato_in    in  DATA_W  read data from the bus interface
//  dir_out    out ADDR_W  address of the current transaction
//  activa     out 1       bus request; held high until fin
//  dato_out   out DATA_W  last captured byte
//  dato_valido out 1      1-cycle pulse when dato_out/indice update
//  indice     out CNT_W   position of dato_out in the burst, 0-based
//  ocupado    out 1       1 in any state except INICIO
//  final      out 1       1-cycle pulse at burst completion
//  error      out 1       1-cycle pulse on num_regs==0, or on timeout
// BEHAVIOUR
//  - Reset (reset=0, async): state=INICIO. All outputs 0. Internal counters 0.
//  - Start: detect the edge with a registered copy of iniciar; edge = iniciar & ~iniciar_q.
//  - States and registered outputs:
//    INICIO: on start edge, latch dir_base/modo and n = min(num_regs, MAX_REGS), set i=0.
//      n==0: error=1 for one cycle, stay in INICIO.
//      Otherwise go to LEE.
//    LEE: activa=1, dir_out = base+i.
//      On fin: dato_out<=dato_in, indice<=i, dato_valido=1 next cycle, activa=0.
//      Then go to SIGUIENTE if i+1<n, else FINALIZAR.
//    SIGUIENTE: activa=0 for exactly 1 cycle; i<=i+1; then LEE.
//    FINALIZAR: final=1 for one cycle. If modo=1 and iniciar=1, set i=0 and go to LEE;
//      otherwise go to INICIO.
//  - Latency: start edge at cycle t -> activa=1 at t+1. fin at t+k -> dato_valido at t+k+1.
//    Next activa rises at t+k+2. After the last fin, final rises 2 cycles later.
//  - Addressing: dir_out = base + i, modulo 2**ADDR_W (wraps, e.g. 8'hFF -> 8'h00).
//  - Abort: iniciar=0 in LEE/SIGUIENTE/FINALIZAR -> INICIO next cycle, activa=0, no final.
//    A fin in that same cycle is discarded.
//  - fin outside LEE is ignored. Inputs other than iniciar are ignored outside INICIO.
//  - Simultaneous events: abort takes priority over fin; timeout takes priority over fin.
// CONFIGURATION
//  LECTURA_TIMEOUT_EN defined: a cycle counter runs in LEE and clears on entry to LEE.
//    If it reaches TO_CYC with no fin: error=1 for one cycle, activa=0, go to INICIO, no final.
//  LECTURA_TIMEOUT_EN undefined: no counter; LEE waits for fin indefinitely; error comes only from n==0.
// TESTING
//  1 dir_base=8'h10, num_regs=3, modo=0, fin 2 cycles after each activa -> dir_out 10/11/12;
//    3 dato_valido pulses with indice 0,1,2; one final; then INICIO.
//  2 dir_base=8'hFE, num_regs=3 -> dir_out FE, FF, 00; final pulses once.
//  3 num_regs=0 -> error pulse 1 cycle after the start edge; activa never rises.
//    num_regs=15 -> exactly 8 reads.
//  4 modo=1, num_regs=2, iniciar held high -> bursts repeat (10,11,final,10,11,...).
//    Drop iniciar during the 2nd LEE -> activa=0 next cycle, no final.
//  5 Pull reset low mid-burst, async to clk -> all outputs 0 immediately.
//    Release it with iniciar still high -> no restart until a new rising edge.
//  6 With LECTURA_TIMEOUT_EN, TO_CYC=255, fin withheld -> error pulse 255 cycles after activa rises;
//    activa falls; state INICIO.

Source files
------------

// File: rtl/lectura_rafaga_if.sv
// Signal bundle for lectura_rafaga: start request, register-bus handshake and read results.
interface lectura_rafaga_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              iniciar;
  logic [ADDR_W-1:0] dir_base;
  logic [CNT_W-1:0]  num_regs;
  logic              modo;
  logic              fin;
  logic [DATA_W-1:0] dato_in;
  logic [ADDR_W-1:0] dir_out;
  logic              activa;
  logic [DATA_W-1:0] dato_out;
  logic              dato_valido;
  logic [CNT_W-1:0]  indice;
  logic              ocupado;
  logic              fin_rafaga;
  logic              error;

  modport slave (
    input  iniciar, dir_base, num_regs, modo, fin, dato_in,
    output dir_out, activa, dato_out, dato_valido, indice, ocupado, fin_rafaga, error
  );

  modport master (
    output iniciar, dir_base, num_regs, modo, fin, dato_in,
    input  dir_out, activa, dato_out, dato_valido, indice, ocupado, fin_rafaga, error
  );
endinterface

// File: rtl/lectura_rafaga.sv
// Burst-read sequencer: reads num_regs registers from dir_base upward over activa/fin.
// Optional LEE watchdog enabled by defining LECTURA_TIMEOUT_EN.
module lectura_rafaga #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_REGS = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TO_CYC   = 255
) (
  input  logic             clk,
  input  logic             reset,
  lectura_rafaga_if.slave  bus
);

  if ((2 ** CNT_W) <= MAX_REGS || TO_CYC == 0) begin : g_param_chk
    $error("lectura_rafaga: CNT_W too narrow for MAX_REGS, or TO_CYC is zero");
  end

  typedef enum logic [1:0] {INICIO, LEE, SIGUIENTE, FINALIZAR} estado_t;

  estado_t           estado, estado_d;
  logic              iniciar_q;
  logic              arranque;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              modo_q, modo_d;
  logic [CNT_W-1:0]  n_q, n_d, i_q, i_d;
  logic [CNT_W-1:0]  n_clamp, i_inc;
  logic [CNT_W:0]    i_sig;
  logic              ultimo;
  logic              timeout;

  logic [ADDR_W-1:0] dir_out_q, dir_out_d;
  logic              activa_q, activa_d;
  logic [DATA_W-1:0] dato_out_q, dato_out_d;
  logic              dato_valido_q, dato_valido_d;
  logic [CNT_W-1:0]  indice_q, indice_d;
  logic              ocupado_q, ocupado_d;
  logic              fin_rafaga_q, fin_rafaga_d;
  logic              error_q, error_d;

  assign arranque = bus.iniciar & ~iniciar_q;
  assign n_clamp  = (bus.num_regs > CNT_W'(MAX_REGS)) ? CNT_W'(MAX_REGS) : bus.num_regs;
  assign i_inc    = CNT_W'(i_q + CNT_W'(1));
  assign i_sig    = {1'b0, i_q} + (CNT_W+1)'(1);
  assign ultimo   = (i_sig >= {1'b0, n_q});

`ifdef LECTURA_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Counts cycles spent in LEE; zero on every entry so each transaction gets a full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else if (estado == LEE && estado_d == LEE) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout = (estado == LEE) && (to_cnt_q == TO_W'(TO_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next state and next values of every registered output.
  always_comb begin
    estado_d      = estado;
    base_d        = base_q;
    modo_d        = modo_q;
    n_d           = n_q;
    i_d           = i_q;
    dir_out_d     = dir_out_q;
    activa_d      = 1'b0;
    dato_out_d    = dato_out_q;
    dato_valido_d = 1'b0;
    indice_d      = indice_q;
    fin_rafaga_d  = 1'b0;
    error_d       = 1'b0;

    case (estado)
      INICIO: begin
        if (arranque) begin
          base_d = bus.dir_base;
          modo_d = bus.modo;
          n_d    = n_clamp;
          i_d    = '0;
          if (n_clamp == '0) begin
            error_d = 1'b1;
          end else begin
            estado_d  = LEE;
            activa_d  = 1'b1;
            dir_out_d = bus.dir_base;
          end
        end
      end

      LEE: begin
        // Abort, then timeout, outrank a coincident fin.
        if (!bus.iniciar) begin
          estado_d = INICIO;
        end else if (timeout) begin
          error_d  = 1'b1;
          estado_d = INICIO;
        end else if (bus.fin) begin
          dato_out_d    = bus.dato_in;
          indice_d      = i_q;
          dato_valido_d = 1'b1;
          estado_d      = ultimo ? FINALIZAR : SIGUIENTE;
        end else begin
          activa_d = 1'b1;
        end
      end

      SIGUIENTE: begin
        if (!bus.iniciar) begin
          estado_d = INICIO;
        end else begin
          i_d       = i_inc;
          estado_d  = LEE;
          activa_d  = 1'b1;
          dir_out_d = base_q + ADDR_W'(i_inc);
        end
      end

      FINALIZAR: begin
        if (!bus.iniciar) begin
          estado_d = INICIO;
        end else begin
          fin_rafaga_d = 1'b1;
          if (modo_q) begin
            i_d       = '0;
            estado_d  = LEE;
            activa_d  = 1'b1;
            dir_out_d = base_q;
          end else begin
            estado_d = INICIO;
          end
        end
      end

      default: estado_d = INICIO;
    endcase

    ocupado_d = (estado_d != INICIO);
  end

  // State and registered outputs. iniciar_q resets high so a level held through reset is no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado        <= INICIO;
      iniciar_q     <= 1'b1;
      base_q        <= '0;
      modo_q        <= 1'b0;
      n_q           <= '0;
      i_q           <= '0;
      dir_out_q     <= '0;
      activa_q      <= 1'b0;
      dato_out_q    <= '0;
      dato_valido_q <= 1'b0;
      indice_q      <= '0;
      ocupado_q     <= 1'b0;
      fin_rafaga_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      estado        <= estado_d;
      iniciar_q     <= bus.iniciar;
      base_q        <= base_d;
      modo_q        <= modo_d;
      n_q           <= n_d;
      i_q           <= i_d;
      dir_out_q     <= dir_out_d;
      activa_q      <= activa_d;
      dato_out_q    <= dato_out_d;
      dato_valido_q <= dato_valido_d;
      indice_q      <= indice_d;
      ocupado_q     <= ocupado_d;
      fin_rafaga_q  <= fin_rafaga_d;
      error_q       <= error_d;
    end
  end

  assign bus.dir_out     = dir_out_q;
  assign bus.activa      = activa_q;
  assign bus.dato_out    = dato_out_q;
  assign bus.dato_valido = dato_valido_q;
  assign bus.indice      = indice_q;
  assign bus.ocupado     = ocupado_q;
  assign bus.fin_rafaga  = fin_rafaga_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_lectura_rafaga.sv
// Self-checking bench for lectura_rafaga: directed and random bursts against an address/count model.
module tb_lectura_rafaga;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rb;
  logic [3:0] rn;

  always #5 clk = ~clk;

  lectura_rafaga_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(4)) bus ();

  lectura_rafaga #(
    .ADDR_W(8), .DATA_W(8), .MAX_REGS(8), .CNT_W(4), .TO_CYC(255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] all_outs();
    return {bus.dir_out, bus.dato_out, bus.indice, bus.activa, bus.dato_valido,
            bus.ocupado, bus.fin_rafaga, bus.error};
  endfunction

  // One transaction: expects activa already high; answers with fin after a random delay.
  task automatic read_one(input logic [7:0] ea, input int idx);
    logic [7:0] d;
    int lat;
    chk("activa_up", 32'(bus.activa), 1);
    chk("dir_out", 32'(bus.dir_out), 32'(ea));
    lat = $urandom_range(0, 3);
    repeat (lat) tick();
    chk("activa_hold", 32'(bus.activa), 1);
    d = 8'($urandom);
    bus.fin = 1'b1;
    bus.dato_in = d;
    tick();
    bus.fin = 1'b0;
    bus.dato_in = 8'($urandom);
    chk("dato_valido", 32'(bus.dato_valido), 1);
    chk("dato_out", 32'(bus.dato_out), 32'(d));
    chk("indice", 32'(bus.indice), 32'(idx));
    chk("activa_down", 32'(bus.activa), 0);
  endtask

  // One-shot burst; other inputs are scrambled after the start edge to prove they are latched.
  task automatic burst(input logic [7:0] base, input logic [3:0] nr);
    int n;
    n = (nr > 4'd8) ? 8 : int'(nr);
    bus.dir_base = base;
    bus.num_regs = nr;
    bus.modo     = 1'b0;
    bus.iniciar  = 1'b1;
    tick();
    bus.dir_base = 8'($urandom);
    bus.num_regs = 4'($urandom);
    bus.modo     = 1'b1;
    if (n == 0) begin
      chk("err_pulse", 32'(bus.error), 1);
      chk("err_noact", 32'(bus.activa), 0);
      tick();
      chk("err_once", 32'(bus.error), 0);
      chk("err_idle", 32'(bus.ocupado), 0);
    end else begin
      for (int k = 0; k < n; k++) begin
        read_one(8'(base + k), k);
        tick();
        if (k < n - 1) chk("no_final_mid", 32'(bus.fin_rafaga), 0);
      end
      chk("final", 32'(bus.fin_rafaga), 1);
      chk("final_idle", 32'(bus.ocupado), 0);
      chk("final_noact", 32'(bus.activa), 0);
      tick();
      chk("final_once", 32'(bus.fin_rafaga), 0);
      chk("no_rearm", 32'(bus.activa), 0);
    end
    bus.iniciar = 1'b0;
    bus.modo    = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    bus.iniciar  = 1'b0;
    bus.dir_base = '0;
    bus.num_regs = '0;
    bus.modo     = 1'b0;
    bus.fin      = 1'b0;
    bus.dato_in  = '0;
    #2;
    chk("reset_outs", 32'(all_outs()), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("idle_outs", 32'(all_outs()), 0);

    burst(8'h10, 4'd3);
    burst(8'hFE, 4'd3);
    burst(8'h00, 4'd0);
    burst(8'h40, 4'd15);

    // Continuous mode: bursts repeat while iniciar stays high; drop it in the 2nd LEE of burst 2.
    bus.dir_base = 8'h10;
    bus.num_regs = 4'd2;
    bus.modo     = 1'b1;
    bus.iniciar  = 1'b1;
    tick();
    read_one(8'h10, 0);
    tick();
    read_one(8'h11, 1);
    tick();
    chk("cont_final", 32'(bus.fin_rafaga), 1);
    chk("cont_rearm", 32'(bus.activa), 1);
    read_one(8'h10, 0);
    tick();
    chk("cont_lee2", 32'(bus.activa), 1);
    bus.iniciar = 1'b0;
    bus.fin     = 1'b1;
    bus.dato_in = 8'hA5;
    tick();
    bus.fin = 1'b0;
    chk("abort_act", 32'(bus.activa), 0);
    chk("abort_fin_drop", 32'(bus.dato_valido), 0);
    chk("abort_idle", 32'(bus.ocupado), 0);
    chk("abort_nofinal", 32'(bus.fin_rafaga), 0);
    tick();
    chk("abort_nofinal2", 32'(bus.fin_rafaga), 0);
    bus.modo = 1'b0;
    tick();

    // Asynchronous reset mid-burst, released with iniciar still high.
    bus.dir_base = 8'h20;
    bus.num_regs = 4'd4;
    bus.iniciar  = 1'b1;
    tick();
    read_one(8'h20, 0);
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset", 32'(all_outs()), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("no_restart", 32'(bus.activa), 0);
    chk("no_restart_idle", 32'(bus.ocupado), 0);
    bus.iniciar = 1'b0;
    tick();
    burst(8'h20, 4'd2);

    for (int r = 0; r < 8; r++) begin
      rb = 8'($urandom);
      rn = 4'($urandom_range(0, 15));
      burst(rb, rn);
    end

`ifdef LECTURA_TIMEOUT_EN
    bus.dir_base = 8'h30;
    bus.num_regs = 4'd1;
    bus.iniciar  = 1'b1;
    tick();
    chk("to_act", 32'(bus.activa), 1);
    repeat (254) tick();
    chk("to_wait", 32'(bus.error), 0);
    chk("to_wait_act", 32'(bus.activa), 1);
    tick();
    chk("to_err", 32'(bus.error), 1);
    chk("to_act_down", 32'(bus.activa), 0);
    chk("to_idle", 32'(bus.ocupado), 0);
    tick();
    chk("to_err_once", 32'(bus.error), 0);
    bus.iniciar = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
